// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU phase sequencer: opcodes, steering control word,
// FSM states and the opcode-to-control decode table.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_SLT   = 4'd5,
        OP_ADDI  = 4'd6,
        OP_PCINC = 4'd7,
        OP_PASSA = 4'd8
    } opcode_e;

    typedef struct packed {
        logic [1:0] alu;
        logic       a_mux;
        logic [1:0] b_mux;
        logic       cin;
        logic       sub;
        logic       stl;
        logic [1:0] mux3;
    } ctl_word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_EVAL,
        ST_UNWIND,
        ST_RESP,
        ST_FAULT
    } state_e;

    localparam int NUM_LEGAL_OPS = 9;

    // Field order: alu, a_mux, b_mux, cin, sub, stl, mux3; indexed by opcode.
    localparam ctl_word_t DECODE_TABLE [NUM_LEGAL_OPS] = '{
        '{2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00},
        '{2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00},
        '{2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00},
        '{2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00},
        '{2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00},
        '{2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 2'b00},
        '{2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00},
        '{2'b00, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00},
        '{2'b00, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 2'b01}
    };

endpackage

// File: rtl/alu_phase_sequencer_if.sv
// Bundle of the opcode handshake, bennett_clock/ALU side signals and the
// result handshake. master = sequencer, slave = surrounding environment.
interface alu_phase_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             op_valid;
    logic             op_ready;
    logic [3:0]       op_code;
    logic             bclk_reset;
    logic             peak_flag;
    logic             inst_flag;
    logic [WIDTH-1:0] alu_out;
    logic             zero_det;
    logic [1:0]       ctl_alu;
    logic             ctl_a_mux;
    logic [1:0]       ctl_b_mux;
    logic             ctl_cin;
    logic             ctl_sub;
    logic             ctl_stl;
    logic [1:0]       ctl_mux3;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_zero;
    logic             res_illegal;
    logic             fault;

    modport master (
        input  op_valid, op_code, peak_flag, inst_flag, alu_out, zero_det, res_ready,
        output op_ready, bclk_reset, ctl_alu, ctl_a_mux, ctl_b_mux, ctl_cin, ctl_sub,
               ctl_stl, ctl_mux3, res_valid, res_data, res_zero, res_illegal, fault
    );

    modport slave (
        output op_valid, op_code, peak_flag, inst_flag, alu_out, zero_det, res_ready,
        input  op_ready, bclk_reset, ctl_alu, ctl_a_mux, ctl_b_mux, ctl_cin, ctl_sub,
               ctl_stl, ctl_mux3, res_valid, res_data, res_zero, res_illegal, fault
    );

endinterface

// File: rtl/alu_op_decoder.sv
// Combinational opcode decode onto the ALU steering control word.
// Undefined opcodes yield an all-zero control word and illegal_o=1.
module alu_op_decoder
    import alu_seq_pkg::*;
(
    input  logic [3:0] op_code_i,
    output ctl_word_t  ctl_o,
    output logic       illegal_o
);

    always_comb begin
        ctl_o     = '0;
        illegal_o = 1'b1;
        if (op_code_i < 4'(NUM_LEGAL_OPS)) begin
            ctl_o     = DECODE_TABLE[op_code_i];
            illegal_o = 1'b0;
        end
    end

endmodule

// File: rtl/alu_phase_sequencer.sv
// Issues one ALU operation per Bennett clock sweep, freezing the steering
// controls from acceptance until the sweep completes, and returns the peak result.
module alu_phase_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64
) (
    input logic                  clk,
    input logic                  reset,
    alu_phase_sequencer_if.master bus
);

    localparam int                CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] WDOG_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    ctl_word_t        ctl_q, ctl_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_zero_q, res_zero_d;
    logic             res_illegal_q, res_illegal_d;
    logic [CNT_W-1:0] wdog_q, wdog_d;

    ctl_word_t        dec_ctl;
    logic             dec_illegal;

    alu_op_decoder u_decoder (
        .op_code_i (bus.op_code),
        .ctl_o     (dec_ctl),
        .illegal_o (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ctl_q         <= '0;
            res_data_q    <= '0;
            res_zero_q    <= 1'b0;
            res_illegal_q <= 1'b0;
            wdog_q        <= '0;
        end else begin
            state_q       <= state_d;
            ctl_q         <= ctl_d;
            res_data_q    <= res_data_d;
            res_zero_q    <= res_zero_d;
            res_illegal_q <= res_illegal_d;
            wdog_q        <= wdog_d;
        end
    end

    // Flags are only looked at in EVAL/UNWIND; everywhere else they are strays.
    always_comb begin
        state_d       = state_q;
        ctl_d         = ctl_q;
        res_data_d    = res_data_q;
        res_zero_d    = res_zero_q;
        res_illegal_d = res_illegal_q;
        wdog_d        = wdog_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.op_valid) begin
                    ctl_d = dec_ctl;
                    if (dec_illegal) begin
                        res_data_d    = '0;
                        res_zero_d    = 1'b0;
                        res_illegal_d = 1'b1;
                        state_d       = ST_RESP;
                    end else begin
                        res_illegal_d = 1'b0;
                        state_d       = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: begin
                wdog_d  = '0;
                state_d = ST_EVAL;
            end
            ST_EVAL: begin
                if (bus.peak_flag) begin
                    res_data_d = bus.alu_out;
                    res_zero_d = bus.zero_det;
                    wdog_d     = '0;
                    state_d    = bus.inst_flag ? ST_RESP : ST_UNWIND;
                end else if (wdog_q == WDOG_LAST) begin
                    ctl_d   = '0;
                    state_d = ST_FAULT;
                end else begin
                    wdog_d = wdog_q + WDOG_ONE;
                end
            end
            ST_UNWIND: begin
                if (bus.inst_flag) begin
                    state_d = ST_RESP;
                end else if (wdog_q == WDOG_LAST) begin
                    ctl_d   = '0;
                    state_d = ST_FAULT;
                end else begin
                    wdog_d = wdog_q + WDOG_ONE;
                end
            end
            ST_RESP: begin
                if (bus.res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FAULT: begin
                ctl_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.op_ready    = (state_q == ST_IDLE);
    assign bus.bclk_reset  = !((state_q == ST_LAUNCH) || (state_q == ST_EVAL) ||
                               (state_q == ST_UNWIND));
    assign bus.ctl_alu     = ctl_q.alu;
    assign bus.ctl_a_mux   = ctl_q.a_mux;
    assign bus.ctl_b_mux   = ctl_q.b_mux;
    assign bus.ctl_cin     = ctl_q.cin;
    assign bus.ctl_sub     = ctl_q.sub;
    assign bus.ctl_stl     = ctl_q.stl;
    assign bus.ctl_mux3    = ctl_q.mux3;
    assign bus.res_valid   = (state_q == ST_RESP);
    assign bus.res_data    = res_data_q;
    assign bus.res_zero    = res_zero_q;
    assign bus.res_illegal = res_illegal_q;
    assign bus.fault       = (state_q == ST_FAULT);

endmodule
